// File: rtl/regfile_dump_tx_pkg.sv
// Shared definitions for the register-file debug dump path: FSM encoding,
// byte geometry and small sizing helpers.
package regfile_dump_tx_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_BITS_SIZE  = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_BITS_SIZE / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned bits);
    return bits / BYTE_W;
  endfunction

  // Counter width that stays at least one bit for single-byte words.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_tx_word_serializer.sv
// Holds one register word and offers it MSB-first, one byte per accepted
// valid/ready handshake; pulses word_done_o as the final byte is taken.
module regfile_dump_tx_word_serializer
  import regfile_dump_tx_pkg::*;
#(
  parameter int unsigned BITS_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [BITS_SIZE-1:0] word_i,
  input  logic                 tx_ready_i,
  output logic [BYTE_W-1:0]    tx_data_o,
  output logic                 tx_valid_o,
  output logic                 word_done_o
);

  localparam int unsigned    NBYTES = bytes_per_word(BITS_SIZE);
  localparam int unsigned    CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  logic [BITS_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 accept;

  assign accept      = valid_q & tx_ready_i;
  assign word_done_o = accept && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Data and valid only move on load or on an accepted byte, so they hold under backpressure.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q << BYTE_W;
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        valid_d = 1'b0;
      end
    end
  end

  assign tx_data_o  = shift_q[BITS_SIZE-1 -: BYTE_W];
  assign tx_valid_o = valid_q;

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks every architectural register through the debug read port and streams
// each value MSB-first as bytes toward the UART transmitter.
module regfile_dump_tx
  import regfile_dump_tx_pkg::*;
#(
  parameter int unsigned BITS_SIZE = 32,
  parameter int unsigned BITS_REGS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [BITS_REGS-1:0] o_dir_debug,
  input  logic [BITS_SIZE-1:0] i_data_debug,
  output logic [BYTE_W-1:0]    o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [BITS_REGS-1:0] LAST_ADDR = '1;

  state_e               state_q, state_d;
  logic [BITS_REGS-1:0] addr_q, addr_d;
  logic                 load_c;
  logic                 word_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // The address only changes on the edge into LATCH, giving the read a full cycle to settle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LATCH;
          addr_d  = '0;
        end
      end
      ST_LATCH: state_d = ST_SEND;
      ST_SEND: begin
        if (word_done) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LATCH;
            addr_d  = addr_q + BITS_REGS'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_c = (state_q == ST_LATCH);
    o_busy = (state_q != ST_IDLE);
    o_done = (state_q == ST_DONE);
  end

  assign o_dir_debug = addr_q;

  regfile_dump_tx_word_serializer #(
    .BITS_SIZE (BITS_SIZE)
  ) u_ser (
    .clk_i       (i_clk),
    .rst_ni      (i_reset),
    .load_i      (load_c),
    .word_i      (i_data_debug),
    .tx_ready_i  (i_tx_ready),
    .tx_data_o   (o_tx_data),
    .tx_valid_o  (o_tx_valid),
    .word_done_o (word_done)
  );

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Scoreboard bench for regfile_dump_tx: expected bytes are queued at each
// start and checked as the UART side accepts them.
module tb_regfile_dump_tx;

  localparam int unsigned NREGS  = 32;
  localparam int unsigned STREAM = 128;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [4:0]  o_dir_debug;
  logic [31:0] i_data_debug;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [NREGS];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  logic [7:0]  held;
  int          vectors     = 0;
  int          miscompares = 0;
  int          bytes_seen  = 0;

  always #5 i_clk = ~i_clk;

  assign i_data_debug = rf[o_dir_debug];

  regfile_dump_tx #(
    .BITS_SIZE (32),
    .BITS_REGS (5)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .o_dir_debug  (o_dir_debug),
    .i_data_debug (i_data_debug),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Scoreboard: every accepted byte is popped and compared in stream order.
  always @(negedge i_clk) begin
    if (i_reset && o_tx_valid && i_tx_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_extra byte %0d: got %02h, required no byte", bytes_seen, o_tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_tx_data !== mon_exp) begin
          miscompares++;
          $display("FAIL stream_byte %0d: got %02h, required %02h", bytes_seen, o_tx_data, mon_exp);
        end
      end
      bytes_seen++;
    end
  end

  task automatic push_dump(input int ovr_addr, input logic [31:0] ovr_val);
    logic [31:0] w;
    for (int a = 0; a < NREGS; a++) begin
      w = (a == ovr_addr) ? ovr_val : rf[a];
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    end
  endtask

  // Leaves the caller 1 time unit after edge k, i.e. inside cycle k+1.
  task automatic pulse_start();
    bytes_seen = 0;
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b0; i_tx_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    vectors += 5;
    if (o_dir_debug !== 5'd0) begin miscompares++; $display("FAIL reset_dir: got %0h, required 0", o_dir_debug); end
    if (o_tx_data !== 8'd0)   begin miscompares++; $display("FAIL reset_data: got %0h, required 0", o_tx_data); end
    if (o_tx_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %0b, required 0", o_tx_valid); end
    if (o_busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %0b, required 0", o_busy); end
    if (o_done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %0b, required 0", o_done); end
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic test_dump_basic();
    for (int a = 0; a < NREGS; a++) rf[a] = 32'(a);
    rf[5] = 32'hDEADBEEF;
    push_dump(-1, 32'd0);
    pulse_start();
    for (int n = 1; n <= 163; n++) begin
      @(negedge i_clk);
      vectors += 2;
      if (o_done !== (n == 161)) begin miscompares++; $display("FAIL basic_done cycle k+%0d: got %0b, required %0b", n, o_done, n == 161); end
      if (o_busy !== (n <= 161)) begin miscompares++; $display("FAIL basic_busy cycle k+%0d: got %0b, required %0b", n, o_busy, n <= 161); end
      if (n == 1) begin
        vectors++;
        if (o_tx_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_latch: got %0b, required 0", o_tx_valid); end
      end
      if (n == 2) begin
        vectors++;
        if (o_tx_valid !== 1'b1) begin miscompares++; $display("FAIL basic_first_valid: got %0b, required 1", o_tx_valid); end
      end
      if (n == 26) begin
        vectors++;
        if (o_dir_debug !== 5'd5) begin miscompares++; $display("FAIL basic_dir_reg5: got %0d, required 5", o_dir_debug); end
      end
      @(posedge i_clk); #1;
    end
    vectors += 2;
    if (bytes_seen !== STREAM) begin miscompares++; $display("FAIL basic_length: got %0d, required %0d", bytes_seen, STREAM); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    push_dump(-1, 32'd0);
    pulse_start();
    for (int n = 1; n <= 166; n++) begin
      @(negedge i_clk);
      if (n >= 12 && n <= 14) begin
        if (n == 12) held = o_tx_data;
        vectors += 3;
        if (o_tx_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid cycle k+%0d: got %0b, required 1", n, o_tx_valid); end
        if (o_tx_data !== 8'h00) begin miscompares++; $display("FAIL bp_data cycle k+%0d: got %02h, required 00", n, o_tx_data); end
        if (o_tx_data !== held)  begin miscompares++; $display("FAIL bp_stable cycle k+%0d: got %02h, required %02h", n, o_tx_data, held); end
      end
      if (n == 164 || n == 161) begin
        vectors++;
        if (o_done !== (n == 164)) begin miscompares++; $display("FAIL bp_done cycle k+%0d: got %0b, required %0b", n, o_done, n == 164); end
      end
      if (n == 165) begin
        vectors++;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy_end: got %0b, required 0", o_busy); end
      end
      @(posedge i_clk); #1;
      i_tx_ready = !(n >= 11 && n <= 13);
    end
    i_tx_ready = 1'b1;
    vectors++;
    if (bytes_seen !== STREAM) begin miscompares++; $display("FAIL bp_length: got %0d, required %0d", bytes_seen, STREAM); end
  endtask

  task automatic test_restart_ignored();
    push_dump(-1, 32'd0);
    pulse_start();
    for (int n = 1; n <= 163; n++) begin
      @(negedge i_clk);
      if (n == 54) begin
        vectors += 2;
        if (o_dir_debug !== 5'd10) begin miscompares++; $display("FAIL restart_dir: got %0d, required 10", o_dir_debug); end
        if (o_busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %0b, required 1", o_busy); end
      end
      if (n == 161 || n == 162) begin
        vectors += 2;
        if (o_done !== (n == 161)) begin miscompares++; $display("FAIL restart_done cycle k+%0d: got %0b, required %0b", n, o_done, n == 161); end
        if (o_busy !== (n == 161)) begin miscompares++; $display("FAIL restart_busy_end cycle k+%0d: got %0b, required %0b", n, o_busy, n == 161); end
      end
      @(posedge i_clk); #1;
      i_start = (n == 52);
    end
    vectors++;
    if (bytes_seen !== STREAM) begin miscompares++; $display("FAIL restart_length: got %0d, required %0d", bytes_seen, STREAM); end
  endtask

  task automatic test_write_during_dump();
    push_dump(20, 32'h12345678);
    pulse_start();
    for (int n = 1; n <= 163; n++) begin
      @(negedge i_clk);
      if (n == 102) begin
        vectors++;
        if (o_tx_data !== 8'h12) begin miscompares++; $display("FAIL write_reg20_byte0: got %02h, required 12", o_tx_data); end
      end
      if (n == 161) begin
        vectors++;
        if (o_done !== 1'b1) begin miscompares++; $display("FAIL write_done: got %0b, required 1", o_done); end
      end
      @(posedge i_clk); #1;
      if (n == 17) rf[20] = 32'h12345678;
    end
    vectors++;
    if (bytes_seen !== STREAM) begin miscompares++; $display("FAIL write_length: got %0d, required %0d", bytes_seen, STREAM); end
  endtask

  task automatic test_reset_mid_dump();
    push_dump(-1, 32'd0);
    pulse_start();
    repeat (38) @(posedge i_clk);
    #2 i_reset = 1'b0;
    exp_q.delete();
    #1;
    vectors += 5;
    if (bytes_seen !== 30)    begin miscompares++; $display("FAIL rst_mid_progress: got %0d, required 30", bytes_seen); end
    if (o_dir_debug !== 5'd0) begin miscompares++; $display("FAIL rst_mid_dir: got %0h, required 0", o_dir_debug); end
    if (o_tx_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_valid: got %0b, required 0", o_tx_valid); end
    if (o_busy !== 1'b0)      begin miscompares++; $display("FAIL rst_mid_busy: got %0b, required 0", o_busy); end
    if (o_tx_data !== 8'd0)   begin miscompares++; $display("FAIL rst_mid_data: got %02h, required 0", o_tx_data); end
    @(posedge i_clk); #1 i_reset = 1'b1;
    push_dump(-1, 32'd0);
    pulse_start();
    for (int n = 1; n <= 163; n++) begin
      @(negedge i_clk);
      if (n == 1) begin
        vectors++;
        if (o_dir_debug !== 5'd0) begin miscompares++; $display("FAIL rst_restart_dir: got %0d, required 0", o_dir_debug); end
      end
      if (n == 161) begin
        vectors++;
        if (o_done !== 1'b1) begin miscompares++; $display("FAIL rst_restart_done: got %0b, required 1", o_done); end
      end
      @(posedge i_clk); #1;
    end
    vectors++;
    if (bytes_seen !== STREAM) begin miscompares++; $display("FAIL rst_restart_length: got %0d, required %0d", bytes_seen, STREAM); end
  endtask

  initial begin
    for (int a = 0; a < NREGS; a++) rf[a] = 32'(a);
    test_reset();
    test_dump_basic();
    test_backpressure();
    test_restart_ignored();
    test_write_during_dump();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
